npc_predict: RTL and testbench
==============================

// Module: npc_predict
// PURPOSE
//  Parametrised next-PC unit with a registered PC and a direct-mapped branch target buffer (BTB).
//  The BTB holds one 2-bit saturating counter per entry. Each cycle the unit predicts the next
//  fetch address from the current PC, and takes branch/jump resolutions back from EX. On a
//  mispredict it redirects fetch and raises flush. Sits in IF; replaces plain pc+4/branch muxing.
// PARAMETERS
//  XLEN        32            address width
//  BTB_ENTRIES 16            BTB depth, power of two >= 2; IDX = log2(BTB_ENTRIES)
//  RESET_PC    32'h0000_3000 PC value after reset
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous reset, active-low
//  stall          in   1     hold PC (IF/ID stall)
//  pc_out         out  XLEN  current fetch PC (registered)
//  pred_taken     out  1     prediction for pc_out (combinational from pc_out + BTB)
//  pred_target    out  XLEN  predicted next PC for pc_out (combinational)
//  ex_valid       in   1     one-cycle pulse: control-flow instr resolved in EX
//  ex_is_jump     in   1     J/JAL/JR (unconditional); else conditional branch
//  ex_pc          in   XLEN  PC of resolved instr
//  ex_taken       in   1     actual outcome (forced 1 when ex_is_jump)
//  ex_target      in   XLEN  actual taken target (jump addr, GPR[rs], or pc+4+(ext<<2))
//  ex_pred_taken  in   1     pred_taken carried down the pipe with the instr
//  ex_pred_target in   XLEN  pred_target carried down the pipe with the instr
//  flush          out  1     mispredict: kill IF/ID and ID/EX (combinational)
//  mispredict_cnt out  32    saturating count of mispredicts
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_out=RESET_PC; all BTB valid=0, counters=0; mispredict_cnt=0.
//  Lookup: idx=pc_out[IDX+1:2], tag=pc_out[XLEN-1:IDX+2]. hit = valid[idx] & tag match.
//   pred_taken = hit & ctr[idx][1]. pred_target = pred_taken ? btb_tgt[idx] : pc_out+4 (mod 2^XLEN).
//  Mispredict (mis) = ex_valid & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)).
//   Comparison uses the effective taken = ex_taken | ex_is_jump.
//  flush = mis, same cycle.
//  Redirect PC = taken ? ex_target : ex_pc+4.
//  PC update on clk edge. Priority: mis -> redirect PC; else stall -> hold; else pred_target.
//   mis overrides stall. Latency: redirect PC appears on pc_out one cycle after flush.
//  BTB update on clk edge when ex_valid. ex_idx and ex_tag are taken from ex_pc.
//   ex entry hit & taken: ctr = min(ctr+1,3); tgt = ex_target.
//   ex entry hit & not taken: ctr = max(ctr-1,0); tgt unchanged.
//   miss & taken: allocate/overwrite entry: valid=1, tag, tgt=ex_target,
//    ctr = ex_is_jump ? 3 : 2.
//   miss & not taken: no change.
//   BTB update is independent of stall.
//  Same-cycle lookup and update to the same idx: lookup sees pre-update contents.
//   The new contents are visible from the next cycle.
//  mispredict_cnt increments on each mis; holds at 32'hFFFF_FFFF.
//  Aliasing: entries with different tags overwrite each other. No set associativity.
//  rst_n low mid-operation: all state returns to reset values immediately.
//   Any in-flight resolution is dropped.
// TESTING
//  1. Reset, no ex_valid, stall=0:
//     pc_out 0x3000,0x3004,0x3008...; pred_taken=0; flush=0; mispredict_cnt=0.
//  2. Branch @0x3010, taken, target 0x3040, first time (pred 0):
//     flush=1 that cycle; next pc_out=0x3040.
//     Entry allocated ctr=2; next fetch of 0x3010 gives pred_taken=1, pred_target=0x3040.
//  3. Same branch resolved taken 2x more, then not-taken:
//     ctr 2->3->3->2, still predicts taken.
//     The not-taken mispredict redirects to 0x3014; mispredict_cnt increments.
//  4. JR @0x3020 to 0x4000, then to 0x5000 (entry ctr=3, tgt 0x4000):
//     target mismatch -> flush, pc_out=0x5000, tgt updated to 0x5000.
//  5. stall=1 with mis in the same cycle: pc_out takes the redirect PC.
//     stall=1 without mis: pc_out holds for every stalled cycle.
//  6. Alias: 0x3010 and 0x3050 (BTB_ENTRIES=16) share an idx.
//     A taken resolution of 0x3050 evicts 0x3010; a lookup of 0x3010 then gives pred_taken=0.
//     Assert rst_n=0 mid-run: pc_out=0x3000 asynchronously, all predictions 0.

Source files
------------

// File: rtl/npc_predict.sv
// Next-PC unit for the IF stage: registered fetch PC plus a direct-mapped BTB of
// 2-bit saturating counters, redirected by branch/jump resolutions coming back from EX.
module npc_predict #(
    parameter int               XLEN        = 32,
    parameter int               BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0]  RESET_PC    = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    output logic [XLEN-1:0]  pc_out,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_jump,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             flush,
    output logic [31:0]      mispredict_cnt
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    logic [IDX-1:0]   look_idx, ex_idx;
    logic [TAGW-1:0]  look_tag, ex_tag;
    logic             look_hit, ex_hit, eff_taken, mis;
    logic             btb_we;
    logic [1:0]       ctr_d;
    logic [XLEN-1:0]  tgt_d, redirect_pc;

    assign look_idx = pc_q[IDX+1:2];
    assign look_tag = pc_q[XLEN-1:IDX+2];
    assign ex_idx   = ex_pc[IDX+1:2];
    assign ex_tag   = ex_pc[XLEN-1:IDX+2];

    assign look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign pred_taken  = look_hit && ctr_q[look_idx][1];
    assign pred_target = pred_taken ? tgt_q[look_idx] : pc_q + XLEN'(4);

    // Jumps are always taken regardless of what EX reports in ex_taken.
    assign eff_taken   = ex_taken || ex_is_jump;
    assign mis         = ex_valid && ((eff_taken != ex_pred_taken) ||
                                      (eff_taken && (ex_target != ex_pred_target)));
    assign flush       = mis;
    assign redirect_pc = eff_taken ? ex_target : ex_pc + XLEN'(4);

    assign pc_out         = pc_q;
    assign mispredict_cnt = cnt_q;

    always_comb begin
        pc_d  = pred_target;
        cnt_d = cnt_q;
        if (mis) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
        if (mis && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        btb_we = 1'b0;
        ctr_d  = ctr_q[ex_idx];
        tgt_d  = tgt_q[ex_idx];
        if (ex_valid) begin
            if (ex_hit) begin
                btb_we = 1'b1;
                if (eff_taken) begin
                    ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
                    tgt_d = ex_target;
                end else begin
                    ctr_d = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (eff_taken) begin
                btb_we = 1'b1;
                ctr_d  = ex_is_jump ? 2'd3 : 2'd2;
                tgt_d  = ex_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    // Written entries become visible to lookup only from the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (btb_we) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            tgt_q[ex_idx]   <= tgt_d;
            ctr_q[ex_idx]   <= ctr_d;
        end
    end

endmodule

// File: tb/tb_npc_predict.sv
// Bench for npc_predict: directed scenarios with literal expectations, then random
// resolutions checked every cycle against a BTB model keyed by the owning word address.
module tb_npc_predict;

    localparam int          BTB      = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic [31:0] pc_out, pred_target, ex_pc, ex_target, ex_pred_target, mispredict_cnt;
    logic        pred_taken, ex_valid, ex_is_jump, ex_taken, ex_pred_taken, flush;

    int checkCount = 0;
    int failCount  = 0;

    // Model: each slot remembers which instruction word owns it.
    bit          ownerValid [BTB];
    logic [29:0] ownerWord  [BTB];
    int          strength   [BTB];
    logic [31:0] dest       [BTB];
    logic [31:0] mPc, mCnt;

    npc_predict dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .pc_out(pc_out), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    function automatic int slotOf(input logic [31:0] a);
        return int'((a >> 2) % 32'(BTB));
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return ownerValid[slotOf(a)] && (ownerWord[slotOf(a)] == a[31:2]);
    endfunction

    function automatic bit modelPredTaken(input logic [31:0] a);
        return modelHit(a) && (strength[slotOf(a)] >= 2);
    endfunction

    function automatic logic [31:0] modelPredTarget(input logic [31:0] a);
        return modelPredTaken(a) ? dest[slotOf(a)] : a + 32'd4;
    endfunction

    function automatic bit modelMis();
        bit eff;
        eff = ex_taken || ex_is_jump;
        return ex_valid && ((eff != ex_pred_taken) || (eff && (ex_target != ex_pred_target)));
    endfunction

    task automatic compareValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < BTB; i++) begin
            ownerValid[i] = 1'b0;
            ownerWord[i]  = '0;
            strength[i]   = 0;
            dest[i]       = '0;
        end
        mPc  = RESET_PC;
        mCnt = '0;
    endtask

    task automatic advanceModel();
        bit          eff, mis, h;
        int          s;
        logic [31:0] nextPc;
        eff = ex_taken || ex_is_jump;
        mis = modelMis();
        s   = slotOf(ex_pc);
        h   = modelHit(ex_pc);
        if (mis)        nextPc = eff ? ex_target : ex_pc + 32'd4;
        else if (stall) nextPc = mPc;
        else            nextPc = modelPredTarget(mPc);
        if (ex_valid) begin
            if (h) begin
                if (eff) begin
                    strength[s] = (strength[s] < 3) ? strength[s] + 1 : 3;
                    dest[s]     = ex_target;
                end else begin
                    strength[s] = (strength[s] > 0) ? strength[s] - 1 : 0;
                end
            end else if (eff) begin
                ownerValid[s] = 1'b1;
                ownerWord[s]  = ex_pc[31:2];
                dest[s]       = ex_target;
                strength[s]   = ex_is_jump ? 3 : 2;
            end
        end
        if (mis && (mCnt != 32'hFFFF_FFFF)) mCnt = mCnt + 32'd1;
        mPc = nextPc;
    endtask

    task automatic checkOutput();
        compareValue("pc_out", pc_out, mPc);
        compareValue("pred_taken", {31'b0, pred_taken}, {31'b0, modelPredTaken(mPc)});
        compareValue("pred_target", pred_target, modelPredTarget(mPc));
        compareValue("flush", {31'b0, flush}, {31'b0, modelMis()});
        compareValue("mispredict_cnt", mispredict_cnt, mCnt);
    endtask

    // Compare process: inputs are stable at the falling edge, so check then advance.
    always @(negedge clk) begin
        if (!rst_n) resetModel();
        checkOutput();
        if (rst_n) advanceModel();
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input bit jump, input bit taken,
                                 input logic [31:0] pc, input logic [31:0] target,
                                 input bit predTaken, input logic [31:0] predTarget);
        ex_valid       = valid;
        ex_is_jump     = jump;
        ex_taken       = taken;
        ex_pc          = pc;
        ex_target      = target;
        ex_pred_taken  = predTaken;
        ex_pred_target = predTarget;
    endtask

    task automatic idleEx();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // A wrongly-predicted not-taken branch just before addr steers fetch onto addr.
    task automatic redirectTo(input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, 1'b0, addr - 32'd4, 32'h0, 1'b1, 32'h0);
        stepCycle();
        idleEx();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pickPc, pickTgt, pickPt;
        bit          pickJump, pickTaken, pickPtk;
        rst_n = 1'b1;
        stall = 1'b0;
        idleEx();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        compareValue("reset_pc", pc_out, 32'h3000);
        compareValue("reset_pred", {31'b0, pred_taken}, 32'd0);
        compareValue("reset_cnt", mispredict_cnt, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            stepCycle();
            compareValue("seq_pc", pc_out, 32'h3000 + 32'(4 * i));
            compareValue("seq_pred", {31'b0, pred_taken}, 32'd0);
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h3010, 32'h3040, 1'b0, 32'h3014);
        #1 compareValue("first_taken_flush", {31'b0, flush}, 32'd1);
        stepCycle();
        idleEx();
        compareValue("first_taken_redirect", pc_out, 32'h3040);
        compareValue("first_taken_cnt", mispredict_cnt, 32'd1);
        redirectTo(32'h3010);
        compareValue("alloc_pred", {31'b0, pred_taken}, 32'd1);
        compareValue("alloc_target", pred_target, 32'h3040);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h3010, 32'h3040, 1'b1, 32'h3040);
        #1 compareValue("correct_no_flush", {31'b0, flush}, 32'd0);
        stepCycle();
        compareValue("follow_pred", pc_out, 32'h3040);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3010, 32'h3040, 1'b1, 32'h3040);
        #1 compareValue("not_taken_flush", {31'b0, flush}, 32'd1);
        stepCycle();
        idleEx();
        compareValue("not_taken_redirect", pc_out, 32'h3014);
        compareValue("not_taken_cnt", mispredict_cnt, 32'd3);
        redirectTo(32'h3010);
        compareValue("weak_taken_pred", {31'b0, pred_taken}, 32'd1);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3020, 32'h4000, 1'b0, 32'h3024);
        #1 compareValue("jr_first_flush", {31'b0, flush}, 32'd1);
        stepCycle();
        idleEx();
        compareValue("jr_first_pc", pc_out, 32'h4000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h3020, 32'h5000, 1'b1, 32'h4000);
        #1 compareValue("jr_target_flush", {31'b0, flush}, 32'd1);
        stepCycle();
        idleEx();
        compareValue("jr_target_pc", pc_out, 32'h5000);
        compareValue("jr_cnt", mispredict_cnt, 32'd6);
        redirectTo(32'h3020);
        compareValue("jr_new_target", pred_target, 32'h5000);

        stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3200, 32'h0, 1'b1, 32'h0);
        stepCycle();
        idleEx();
        compareValue("stall_mis_pc", pc_out, 32'h3204);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            compareValue("stall_hold_pc", pc_out, 32'h3204);
        end
        stall = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h3050, 32'h3080, 1'b0, 32'h3054);
        stepCycle();
        idleEx();
        compareValue("alias_pc", pc_out, 32'h3080);
        redirectTo(32'h3010);
        compareValue("alias_evicted_pred", {31'b0, pred_taken}, 32'd0);
        compareValue("alias_evicted_target", pred_target, 32'h3014);
        redirectTo(32'h3050);
        compareValue("alias_owner_pred", {31'b0, pred_taken}, 32'd1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 compareValue("async_reset_pc", pc_out, 32'h3000);
        compareValue("async_reset_pred", {31'b0, pred_taken}, 32'd0);
        compareValue("async_reset_cnt", mispredict_cnt, 32'd0);
        stepCycle();
        rst_n = 1'b1;
        repeat (4) stepCycle();
        compareValue("post_reset_pc", pc_out, 32'h3010);
        compareValue("post_reset_pred", {31'b0, pred_taken}, 32'd0);

        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                idleEx();
                rst_n = 1'b0;
                stepCycle();
                rst_n = 1'b1;
            end else begin
                stall = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) < 4) begin
                    pickPc    = 32'h3000 + 32'(4 * $urandom_range(0, 63));
                    pickTgt   = 32'h3000 + 32'(4 * $urandom_range(0, 63));
                    pickJump  = ($urandom_range(0, 4) == 0);
                    pickTaken = 1'($urandom);
                    if (1'($urandom)) begin
                        pickPtk = modelPredTaken(pickPc);
                        pickPt  = modelPredTarget(pickPc);
                    end else begin
                        pickPtk = 1'($urandom);
                        pickPt  = 32'h3000 + 32'(4 * $urandom_range(0, 63));
                    end
                    applyStimulus(1'b1, pickJump, pickTaken, pickPc, pickTgt, pickPtk, pickPt);
                end else begin
                    idleEx();
                end
                stepCycle();
            end
        end

        idleEx();
        stall = 1'b0;
        stepCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
